// File: rtl/operand_fetch.sv
// Register file with write-first bypass and a registered operand pair feeding the ALU.
// Register 0 is hard-wired to zero; the operand stage freezes on stall.
module operand_fetch #(
    parameter int unsigned WORD = 32,
    parameter int unsigned ADDR = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [ADDR-1:0] rdAddrA,
    input  logic [ADDR-1:0] rdAddrB,
    input  logic [2:0]      funcIn,
    input  logic            stall,
    input  logic            wrEn,
    input  logic [ADDR-1:0] wrAddr,
    input  logic [WORD-1:0] wrData,
    output logic [WORD-1:0] opA,
    output logic [WORD-1:0] opB,
    output logic [2:0]      funcOut,
    output logic            opValid
);

    localparam int unsigned DEPTH = 2 ** ADDR;

    logic [WORD-1:0] regs [DEPTH];
    logic [WORD-1:0] val_a;
    logic [WORD-1:0] val_b;
    logic            wr_ok;

    assign wr_ok = wrEn && (wrAddr != '0);

    // Read value with register-0 forcing and same-cycle writeback bypass
    function automatic logic [WORD-1:0] rd_value(input logic [ADDR-1:0] addr);
        logic [WORD-1:0] v;
        v = '0;
        if (addr != '0) begin
            if (wrEn && (wrAddr == addr)) begin
                v = wrData;
            end else begin
                v = regs[addr];
            end
        end
        return v;
    endfunction

    always_comb begin
        val_a = rd_value(rdAddrA);
        val_b = rd_value(rdAddrB);
    end

    // Register file storage; writes are independent of stall
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Operand stage: capture on issue, bubble on idle, hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            opA     <= '0;
            opB     <= '0;
            funcOut <= '0;
            opValid <= 1'b0;
        end else if (!stall) begin
            if (issue) begin
                opA     <= val_a;
                opB     <= val_b;
                funcOut <= funcIn;
                opValid <= 1'b1;
            end else begin
                opValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a reference register-file model predicts
// each issued operand pair into a scoreboard queue that is drained as results appear.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue = 1'b0;
    logic [4:0]  rdAddrA = '0;
    logic [4:0]  rdAddrB = '0;
    logic [2:0]  funcIn = '0;
    logic        stall = 1'b0;
    logic        wrEn = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [2:0]  funcOut;
    logic        opValid;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t         sb[$];
    op_t         e;
    logic [31:0] mdl [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    operand_fetch #(.WORD(32), .ADDR(5)) dut (
        .clk(clk), .rst(rst), .issue(issue), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .funcIn(funcIn), .stall(stall), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .opA(opA), .opB(opB), .funcOut(funcOut), .opValid(opValid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mval(input logic [4:0] x);
        if (x == 5'd0) return 32'h0;
        if (wrEn && wrAddr == x) return wrData;
        return mdl[x];
    endfunction

    // Predict, update the model, advance one edge and settle
    task automatic tick();
        if (!rst && !stall && issue) sb.push_back({funcIn, mval(rdAddrA), mval(rdAddrB)});
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (wrEn && wrAddr != 5'd0) begin
            mdl[wrAddr] = wrData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; issue = 1'b0; stall = 1'b0; wrEn = 1'b0;
        rdAddrA = '0; rdAddrB = '0; funcIn = '0; wrAddr = '0; wrData = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hDEAD_BEEF; issue = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({opValid, funcOut, opA, opB} !== 68'h0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b f=%h a=%h b=%h want all zero", opValid, funcOut, opA, opB);
        end
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd3; rdAddrB = 5'd7;
        tick();
        issue = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL reset_first_issue: scoreboard empty");
        end else begin
            e = sb.pop_front(); n_cmp++;
            if ({opValid, funcOut, opA, opB} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL reset_first_issue: got v=%b a=%h b=%h want v=1 a=%h b=%h", opValid, opA, opB, e.a, e.b);
            end
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h0000_00AA;
        tick();
        n_cmp++;
        if (opValid !== 1'b0) begin
            n_bad++; $display("FAIL bubble_valid: got %b want 0", opValid);
        end
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd5; rdAddrB = 5'd0; funcIn = 3'b010;
        tick();
        issue = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL write_read: scoreboard empty");
        end else begin
            e = sb.pop_front(); n_cmp++;
            if ({opValid, funcOut, opA, opB} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL write_read: got v=%b f=%b a=%h b=%h want v=1 f=%b a=%h b=%h", opValid, funcOut, opA, opB, e.f, e.a, e.b);
            end
        end
        n_cmp++;
        if (opA !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL write_read_const: got %h want 000000aa", opA);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h0000_1234;
        issue = 1'b1; rdAddrA = 5'd9; rdAddrB = 5'd9; funcIn = 3'b101;
        tick();
        if (sb.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL bypass: scoreboard empty");
        end else begin
            e = sb.pop_front(); n_cmp++;
            if ({opValid, funcOut, opA, opB} !== {1'b1, e}) begin
                n_bad++; $display("FAIL bypass: got a=%h b=%h want a=%h b=%h", opA, opB, e.a, e.b);
            end
        end
        n_cmp++;
        if (opA !== 32'h0000_1234 || opB !== 32'h0000_1234) begin
            n_bad++; $display("FAIL bypass_same_addr: got a=%h b=%h want 00001234", opA, opB);
        end
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd9; rdAddrB = 5'd5;
        tick();
        void'(sb.pop_front());
        n_cmp++;
        if (opA !== 32'h0000_1234 || opB !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL bypass_retained: got a=%h b=%h want 00001234 000000aa", opA, opB);
        end
    endtask

    task automatic test_reg0();
        idle_inputs();
        wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFF_FFFF;
        issue = 1'b1; rdAddrA = 5'd0; rdAddrB = 5'd9; funcIn = 3'b111;
        tick();
        void'(sb.pop_front());
        n_cmp++;
        if (opA !== 32'h0 || funcOut !== 3'b111) begin
            n_bad++; $display("FAIL reg0_same_cycle: got a=%h f=%b want 0 111", opA, funcOut);
        end
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd0; rdAddrB = 5'd0;
        tick();
        void'(sb.pop_front());
        n_cmp++;
        if (opA !== 32'h0 || opB !== 32'h0) begin
            n_bad++; $display("FAIL reg0_after_write: got a=%h b=%h want 0", opA, opB);
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd5; rdAddrB = 5'd9; funcIn = 3'b001;
        tick();
        void'(sb.pop_front());
        n_cmp++;
        if (opA !== 32'h0000_00AA || opValid !== 1'b1) begin
            n_bad++; $display("FAIL stall_setup: got a=%h v=%b want 000000aa 1", opA, opValid);
        end
        stall = 1'b1; rdAddrA = 5'd5; rdAddrB = 5'd5; funcIn = 3'b110;
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h0000_00BB;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (opA !== 32'h0000_00AA || opB !== 32'h0000_1234 || funcOut !== 3'b001 || opValid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got a=%h b=%h f=%b v=%b want 000000aa 00001234 001 1", c, opA, opB, funcOut, opValid);
            end
        end
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd5; rdAddrB = 5'd0; funcIn = 3'b011;
        tick();
        if (sb.size() != 1) begin
            n_cmp++; n_bad++; $display("FAIL stall_release: scoreboard size %0d want 1", sb.size());
            sb.delete();
        end else begin
            e = sb.pop_front(); n_cmp++;
            if ({opValid, funcOut, opA, opB} !== {1'b1, e} || opA !== 32'h0000_00BB) begin
                n_bad++; $display("FAIL stall_release: got a=%h f=%b want a=000000bb f=011", opA, funcOut);
            end
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (opValid !== 1'b0 || opA !== 32'h0000_00BB) begin
            n_bad++; $display("FAIL bubble_hold: got v=%b a=%h want 0 000000bb", opValid, opA);
        end
    endtask

    task automatic test_back_to_back();
        logic iss;
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            iss     = ($urandom_range(0, 3) != 0);
            issue   = iss;
            rdAddrA = 5'($urandom_range(0, 31));
            rdAddrB = ($urandom_range(0, 3) == 0) ? rdAddrA : 5'($urandom_range(0, 31));
            funcIn  = 3'($urandom_range(0, 7));
            wrEn    = ($urandom_range(0, 1) == 1);
            wrAddr  = ($urandom_range(0, 2) == 0) ? rdAddrA : 5'($urandom_range(0, 31));
            wrData  = $urandom;
            tick();
            if (iss) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL b2b[%0d]: scoreboard empty", c);
                end else begin
                    e = sb.pop_front(); n_cmp++;
                    if ({opValid, funcOut, opA, opB} !== {1'b1, e}) begin
                        n_bad++;
                        $display("FAIL b2b[%0d]: got v=%b f=%b a=%h b=%h want v=1 f=%b a=%h b=%h", c, opValid, funcOut, opA, opB, e.f, e.a, e.b);
                    end
                end
            end else begin
                n_cmp++;
                if (opValid !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_bubble[%0d]: got v=%b want 0", c, opValid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'h0000_0055;
        issue = 1'b1; rdAddrA = 5'd4; rdAddrB = 5'd4;
        tick();
        void'(sb.pop_front());
        rst = 1'b1; stall = 1'b1; issue = 1'b1;
        wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'h0000_0077;
        tick();
        sb.delete();
        n_cmp++;
        if (opValid !== 1'b0 || opA !== 32'h0 || opB !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid: got v=%b a=%h b=%h want 0 0 0", opValid, opA, opB);
        end
        idle_inputs();
        issue = 1'b1; rdAddrA = 5'd4; rdAddrB = 5'd5;
        tick();
        if (sb.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL reset_mid_read: scoreboard empty");
        end else begin
            e = sb.pop_front(); n_cmp++;
            if ({opValid, funcOut, opA, opB} !== {1'b1, e} || opA !== 32'h0 || opB !== 32'h0) begin
                n_bad++; $display("FAIL reset_mid_read: got a=%h b=%h want 0 0", opA, opB);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        test_reset();
        test_write_read();
        test_bypass();
        test_reg0();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
